// File: rtl/block_decrypt_manager.sv
`default_nettype none
// ============================================================================
// Module   : block_decrypt_manager
// Purpose  : Streams an encrypted image out of frame RAM one byte at a time,
//            packs the bytes into BLOCK_BYTES-wide blocks, hands each block to
//            an external block-cipher core over a start/done handshake and
//            writes the plaintext bytes back to RAM.
// Ports    : clk_i, rst_ni (async, active-low)
//            decrypter_active_i  run request / abort (level)
//            key_i               key, captured at run start
//            read_addr_o / encrypted_data_i      RAM read port (1-cycle latency)
//            write_addr_o / decrypted_data_o / write_en_o   RAM write port
//            core_start_o / core_block_o / core_key_o       request to cipher core
//            core_result_i / core_done_i                    response from cipher core
//            busy_o, done_o      run status
//            iv_i                initial chaining value (CBC build only)
// Config   : CBC_MODE_EN defined   -> CBC chaining with iv_i port
//            CBC_MODE_EN undefined -> ECB, no iv_i port
// Revision : 1.0  initial release
// ============================================================================
module block_decrypt_manager #(
  parameter int ADDR_W      = 15,
  parameter int NUM_BYTES   = 19200,
  parameter int BLOCK_BYTES = 8,
  parameter int KEY_W       = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     decrypter_active_i,
  input  logic [KEY_W-1:0]         key_i,
  output logic [ADDR_W-1:0]        read_addr_o,
  input  logic [7:0]               encrypted_data_i,
  output logic [ADDR_W-1:0]        write_addr_o,
  output logic [7:0]               decrypted_data_o,
  output logic                     write_en_o,
  output logic                     core_start_o,
  output logic [8*BLOCK_BYTES-1:0] core_block_o,
  output logic [KEY_W-1:0]         core_key_o,
  input  logic [8*BLOCK_BYTES-1:0] core_result_i,
  input  logic                     core_done_i,
`ifdef CBC_MODE_EN
  input  logic [8*BLOCK_BYTES-1:0] iv_i,
`endif
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int CW = $clog2(BLOCK_BYTES + 1);
  localparam int IW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [ADDR_W:0] NUM_BYTES_W = (ADDR_W+1)'(NUM_BYTES);
  localparam logic [ADDR_W:0] BLOCK_W     = (ADDR_W+1)'(BLOCK_BYTES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_CSTART = 3'd2;
  localparam logic [2:0] S_CWAIT  = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]                        state_q, state_d;
  logic [ADDR_W:0]                   base_q;    // first byte address of current block
  logic [CW-1:0]                     cnt_q;     // cycle/byte index inside READ or WRITE
  logic [KEY_W-1:0]                  key_q;
  logic [BLOCK_BYTES-1:0][7:0]       blk_q;     // ciphertext block, byte 0 in LSBs
  logic [BLOCK_BYTES-1:0][7:0]       res_q;     // plaintext block
`ifdef CBC_MODE_EN
  logic [8*BLOCK_BYTES-1:0]          chain_q;
`endif

  logic [ADDR_W:0]   w_rem;
  logic [CW-1:0]     w_len;       // bytes in the current (possibly partial) block
  logic [ADDR_W:0]   w_next_base;
  logic [ADDR_W-1:0] w_addr;
  logic [IW-1:0]     w_rd_idx;
  logic [IW-1:0]     w_wr_idx;

  assign w_rem       = NUM_BYTES_W - base_q;
  assign w_len       = (w_rem >= BLOCK_W) ? CW'(BLOCK_BYTES) : CW'(w_rem);
  assign w_next_base = base_q + (ADDR_W+1)'(w_len);
  assign w_addr      = base_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
  // Read data lags the issued address by one cycle.
  assign w_rd_idx    = IW'(cnt_q - CW'(1));
  assign w_wr_idx    = IW'(cnt_q);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (decrypter_active_i) state_d = S_READ;
      S_READ:   if (!decrypter_active_i) state_d = S_IDLE;
                else if (cnt_q == w_len) state_d = S_CSTART;
      S_CSTART: state_d = decrypter_active_i ? S_CWAIT : S_IDLE;
      S_CWAIT:  if (!decrypter_active_i) state_d = S_IDLE;
                else if (core_done_i) state_d = S_WRITE;
      S_WRITE:  if (!decrypter_active_i) state_d = S_IDLE;
                else if (cnt_q == w_len - CW'(1))
                  state_d = (w_next_base == NUM_BYTES_W) ? S_DONE : S_READ;
      S_DONE:   if (!decrypter_active_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q  <= '0;
      cnt_q   <= '0;
      key_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
`ifdef CBC_MODE_EN
      chain_q <= '0;
`endif
    end else if (!decrypter_active_i) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          key_q   <= key_i;
          base_q  <= '0;
          cnt_q   <= '0;
          blk_q   <= '0;
`ifdef CBC_MODE_EN
          chain_q <= iv_i;
`endif
        end
        S_READ: begin
          if (cnt_q != '0) blk_q[w_rd_idx] <= encrypted_data_i;
          cnt_q <= (cnt_q == w_len) ? '0 : cnt_q + CW'(1);
        end
        S_CWAIT: begin
          if (core_done_i) begin
`ifdef CBC_MODE_EN
            res_q <= core_result_i ^ chain_q;
`else
            res_q <= core_result_i;
`endif
          end
        end
        S_WRITE: begin
          if (cnt_q == w_len - CW'(1)) begin
            cnt_q  <= '0;
            base_q <= w_next_base;
            // Clear so a partial final block is zero-padded.
            blk_q  <= '0;
`ifdef CBC_MODE_EN
            chain_q <= blk_q;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic; strobes are gated by the run request so an abort
  // suppresses them in the same cycle.
  always_comb begin
    read_addr_o      = '0;
    write_addr_o     = '0;
    decrypted_data_o = '0;
    write_en_o       = 1'b0;
    core_start_o     = 1'b0;
    busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
    done_o           = (state_q == S_DONE);
    case (state_q)
      S_READ:   if (cnt_q < w_len) read_addr_o = w_addr;
      S_CSTART: core_start_o = decrypter_active_i;
      S_WRITE: begin
        write_en_o       = decrypter_active_i;
        write_addr_o     = w_addr;
        decrypted_data_o = res_q[w_wr_idx];
      end
      default: ;
    endcase
  end

  assign core_block_o = blk_q;
  assign core_key_o   = key_q;

endmodule
`default_nettype wire

// File: tb/tb_block_decrypt_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_decrypt_manager
// Purpose  : Self-checking bench for block_decrypt_manager with a RAM model,
//            a cipher-core model and an image-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_block_decrypt_manager;

  localparam int ADDR_W = 5;
  localparam int NB     = 20;
  localparam int BB     = 8;
  localparam int KEY_W  = 64;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              active;
  logic [63:0]       key;
  logic [ADDR_W-1:0] read_addr_o;
  logic [7:0]        rdata;
  logic [ADDR_W-1:0] write_addr_o;
  logic [7:0]        decrypted_data_o;
  logic              write_en_o;
  logic              core_start_o;
  logic [63:0]       core_block_o;
  logic [63:0]       core_key_o;
  logic [63:0]       core_result;
  logic              core_done;
  logic              busy_o;
  logic              done_o;
`ifdef CBC_MODE_EN
  logic [63:0]       iv;
`endif

  always #5 clk = ~clk;

  block_decrypt_manager #(
    .ADDR_W(ADDR_W), .NUM_BYTES(NB), .BLOCK_BYTES(BB), .KEY_W(KEY_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .decrypter_active_i(active), .key_i(key),
    .read_addr_o(read_addr_o), .encrypted_data_i(rdata),
    .write_addr_o(write_addr_o), .decrypted_data_o(decrypted_data_o),
    .write_en_o(write_en_o), .core_start_o(core_start_o),
    .core_block_o(core_block_o), .core_key_o(core_key_o),
    .core_result_i(core_result), .core_done_i(core_done),
`ifdef CBC_MODE_EN
    .iv_i(iv),
`endif
    .busy_o(busy_o), .done_o(done_o)
  );

  // Synchronous-read RAM
  logic [7:0] mem [32];
  always @(posedge clk) rdata <= mem[read_addr_o];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stand-in cipher: any fixed bijective-looking mix of block and key.
  function automatic logic [63:0] core_f(input logic [63:0] b, input logic [63:0] k);
    return {b[31:0], b[63:32]} ^ k ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  // Reference expectations for one whole-image run
  logic [15:0] exp_wr[$];   // {addr, data}
  logic [63:0] exp_blk[$];
  logic [63:0] exp_key;

  task automatic build_exp(input logic [63:0] k);
    logic [63:0] blk, res;
    logic [7:0]  a;
`ifdef CBC_MODE_EN
    logic [63:0] chain = iv;
`endif
    exp_wr.delete();
    exp_blk.delete();
    exp_key = k;
    for (int base = 0; base < NB; base += BB) begin
      blk = '0;
      for (int j = 0; j < BB && base + j < NB; j++) blk[8*j +: 8] = mem[base + j];
      exp_blk.push_back(blk);
      res = core_f(blk, k);
`ifdef CBC_MODE_EN
      res   = res ^ chain;
      chain = blk;
`endif
      for (int j = 0; j < BB && base + j < NB; j++) begin
        a = 8'(base + j);
        exp_wr.push_back({a, res[8*j +: 8]});
      end
    end
  endtask

  // Cipher-core model and output monitor, sampled on the falling edge
  bit          pend = 0;
  int          cd = 0;
  int          fixed_lat = -1;
  int          starts = 0;
  int          writes = 0;
  logic [63:0] res_pend;
  logic [63:0] first_blk = '0;
  logic [15:0] ew;
  logic [63:0] eb;

  always @(negedge clk) begin
    if (!rst_ni) begin
      pend      = 0;
      core_done = 1'b0;
    end else begin
      core_done = 1'b0;
      if (pend) begin
        if (cd == 0) begin
          core_done   = 1'b1;
          core_result = res_pend;
          pend        = 0;
        end else cd--;
      end
      if (write_en_o) begin
        writes++;
        if (exp_wr.size() == 0) check("wr_unexp", 1, 0);
        else begin
          ew = exp_wr.pop_front();
          check("wr_addr", 64'(write_addr_o), 64'(ew[15:8]));
          check("wr_data", 64'(decrypted_data_o), 64'(ew[7:0]));
        end
      end
      if (core_start_o) begin
        if (starts == 0) first_blk = core_block_o;
        starts++;
        if (exp_blk.size() == 0) check("start_unexp", 1, 0);
        else begin
          eb = exp_blk.pop_front();
          check("core_blk", core_block_o, eb);
          check("core_key", core_key_o, exp_key);
        end
        res_pend = core_f(core_block_o, core_key_o);
        pend     = 1;
        cd       = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
      end
      if (busy_o) check("rd_range", 64'(read_addr_o < NB), 1);
    end
  end

  task automatic run_image(input logic [63:0] k, input bit chg);
    bit ok = 0;
    int s0 = starts;
    build_exp(k);
    key    = k;
    active = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk); #1;
      if (chg && i == 12) key = {$urandom, $urandom};
      if (done_o) ok = 1;
    end
    check("done_seen", 64'(ok), 1);
    repeat (3) @(posedge clk);
    #1;
    check("done_hold", 64'(done_o), 1);
    check("busy_in_done", 64'(busy_o), 0);
    check("wr_left", 64'(exp_wr.size()), 0);
    check("blk_left", 64'(exp_blk.size()), 0);
    check("n_starts", 64'(starts - s0), 3);
    active = 1'b0;
    @(posedge clk); #1;
    check("done_clr", 64'(done_o), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    logic [7:0] spec_bytes [8];
    bit seen;
    int w0;
    spec_bytes = '{8'h65, 8'hA7, 8'h65, 8'h92, 8'hF8, 8'hFB, 8'hA6, 8'hE0};
    rst_ni = 1'b0; active = 1'b0; key = '0;
    core_done = 1'b0; core_result = '0;
`ifdef CBC_MODE_EN
    iv = '1;
`endif
    fill_random();
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {core_block_o[31:0], core_key_o[15:0], 8'(read_addr_o), 8'(write_addr_o)}, 0);
    rst_ni = 1'b1;

    // Idle after reset with no request
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_outs", 64'({busy_o, done_o, write_en_o, core_start_o, decrypted_data_o}), 0);
    end
    check("idle_blk", core_block_o, 0);
    check("idle_key", core_key_o, 0);

    // Known first block, then a partial final block
    for (int i = 0; i < 8; i++) mem[i] = spec_bytes[i];
    run_image(64'h1334_5779_9BBC_DFF1, 0);
    check("spec_vec", first_blk, 64'hE0A6_FBF8_9265_A765);

    // Random image, key changed mid-run
    fill_random();
    run_image({$urandom, $urandom}, 1);

    // Abort during CORE_WAIT; the late core_done must be ignored
    fill_random();
    build_exp({$urandom, $urandom});
    key = exp_key; fixed_lat = 3; w0 = writes; seen = 0;
    active = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (starts > 0 && dut.busy_o && !core_start_o && exp_blk.size() == 2) seen = 1;
    end
    check("abort_reach", 64'(seen), 1);
    active = 1'b0;
    exp_wr.delete(); exp_blk.delete();
    repeat (10) @(posedge clk);
    #1;
    check("abort_wr", 64'(writes - w0), 0);
    check("abort_busy", 64'(busy_o), 0);
    check("abort_done", 64'(done_o), 0);
    fixed_lat = -1;

    // Restart after abort begins from address 0
    run_image({$urandom, $urandom}, 0);

    // Reset mid-run
    fill_random();
    build_exp({$urandom, $urandom});
    key = exp_key; active = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    check("mrst_busy", 64'(busy_o), 0);
    check("mrst_blk", core_block_o, 0);
    check("mrst_key", core_key_o, 0);
    check("mrst_strb", 64'({write_en_o, core_start_o, done_o}), 0);
    exp_wr.delete(); exp_blk.delete();
    active = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Full run after reset
    fill_random();
    run_image({$urandom, $urandom}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
